// File: rtl/vec_rf_pkg.sv
// Shared types, default sizes and lane-mask helper for the vector register file.
package vec_rf_pkg;

    localparam int DEF_REG_SIZE = 8;
    localparam int DEF_REG_QTY  = 8;
    localparam int DEF_VEC_SIZE = 4;
    localparam int MAX_LANES    = 32;

    typedef logic [DEF_REG_SIZE-1:0] lane_t;
    typedef lane_t [DEF_VEC_SIZE-1:0] vec_t;

    // Scalar writebacks touch lane 0 only; callers truncate to their lane count.
    function automatic logic [MAX_LANES-1:0] eff_mask(input logic                 wr_scalar,
                                                      input logic [MAX_LANES-1:0] wr_mask);
        logic [MAX_LANES-1:0] m;
        m = wr_scalar ? {{(MAX_LANES-1){1'b0}}, 1'b1} : wr_mask;
        return m;
    endfunction

endpackage

// File: rtl/vec_rf_scoreboard.sv
// Per-register busy tracking and read-source hazard detection for issue stalls.
module vec_rf_scoreboard
    import vec_rf_pkg::*;
#(
    parameter int REG_QTY  = DEF_REG_QTY,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(REG_QTY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_en,
    input  logic [AW-1:0]      issue_dst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_sel,
    input  logic [AW-1:0]      rd_sel1,
    input  logic [AW-1:0]      rd_sel2,
    output logic [REG_QTY-1:0] busy,
    output logic               hazard
);

    logic [REG_QTY-1:0] r_busy;
    logic [REG_QTY-1:0] w_busy_nxt;
    logic               w_hz1;
    logic               w_hz2;

    // A same-cycle issue wins over a completing writeback: the newer producer is still pending.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < REG_QTY; r++) begin
            if (issue_en && issue_dst == AW'(r)) begin
                w_busy_nxt[r] = 1'b1;
            end else if (wr_en && wr_sel == AW'(r)) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Any writeback to the source completes its producer, even with a partial mask.
    always_comb begin
        w_hz1  = r_busy[rd_sel1] && !(wr_en && wr_sel == rd_sel1);
        w_hz2  = r_busy[rd_sel2] && !(wr_en && wr_sel == rd_sel2);
        hazard = w_hz1 | w_hz2;
        busy   = r_busy;
    end

endmodule

// File: rtl/vec_reg_file_sb.sv
// Vector register file with per-lane masked writes, per-lane write bypass and hazard scoreboard.
module vec_reg_file_sb
    import vec_rf_pkg::*;
#(
    parameter int REG_SIZE = DEF_REG_SIZE,
    parameter int REG_QTY  = DEF_REG_QTY,
    parameter int VEC_SIZE = DEF_VEC_SIZE,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(REG_QTY)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [AW-1:0]                      rd_sel1,
    input  logic [AW-1:0]                      rd_sel2,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  rd_data1,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  rd_data2,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_sel,
    input  logic                               wr_scalar,
    input  logic [VEC_SIZE-1:0]                wr_mask,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  wr_data,
    input  logic                               issue_en,
    input  logic [AW-1:0]                      issue_dst,
    output logic                               hazard,
    output logic [REG_QTY-1:0]                 busy
);

    logic [VEC_SIZE-1:0][REG_SIZE-1:0] r_regs [REG_QTY];
    logic [VEC_SIZE-1:0]               w_em;
    logic                              w_wr_drop;

    assign w_em      = VEC_SIZE'(eff_mask(wr_scalar, MAX_LANES'(wr_mask)));
    assign w_wr_drop = (ZERO_REG != 0) && (wr_sel == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REG_QTY; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wr_en && !w_wr_drop) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                if (w_em[i]) begin
                    r_regs[wr_sel][i] <= wr_data[i];
                end
            end
        end
    end

    // Bypass is per lane; the hard-wired zero register overrides it.
    always_comb begin
        rd_data1 = r_regs[rd_sel1];
        rd_data2 = r_regs[rd_sel2];
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (wr_en && wr_sel == rd_sel1 && w_em[i]) begin
                rd_data1[i] = wr_data[i];
            end
            if (wr_en && wr_sel == rd_sel2 && w_em[i]) begin
                rd_data2[i] = wr_data[i];
            end
        end
        if ((ZERO_REG != 0) && rd_sel1 == '0) begin
            rd_data1 = '0;
        end
        if ((ZERO_REG != 0) && rd_sel2 == '0) begin
            rd_data2 = '0;
        end
    end

    vec_rf_scoreboard #(
        .REG_QTY  (REG_QTY),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .busy      (busy),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_vec_reg_file_sb.sv
// Directed bench for vec_reg_file_sb: driver pushes expected outputs, negedge monitor compares.
module tb_vec_reg_file_sb;
    import vec_rf_pkg::*;

    localparam int W = 73;

    logic        clk;
    logic        reset;
    logic [2:0]  rd_sel1;
    logic [2:0]  rd_sel2;
    vec_t        rd_data1;
    vec_t        rd_data2;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic        wr_scalar;
    logic [3:0]  wr_mask;
    vec_t        wr_data;
    logic        issue_en;
    logic [2:0]  issue_dst;
    logic        hazard;
    logic [7:0]  busy;

    logic        chk_valid;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        name_q[$];
    int           total;
    int           bad;

    localparam logic [W-1:0] M_D1 = {32'hFFFF_FFFF, 32'h0, 8'h0, 1'b0};
    localparam logic [W-1:0] M_D2 = {32'h0, 32'hFFFF_FFFF, 8'h0, 1'b0};
    localparam logic [W-1:0] M_BZ = {32'h0, 32'h0, 8'hFF, 1'b0};
    localparam logic [W-1:0] M_HZ = {32'h0, 32'h0, 8'h0, 1'b1};

    vec_reg_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_scalar (wr_scalar),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .hazard    (hazard),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        reset     = 1'b0;
        wr_en     = 1'b0;
        wr_scalar = 1'b0;
        wr_mask   = 4'h0;
        wr_sel    = 3'd0;
        wr_data   = '0;
        issue_en  = 1'b0;
        issue_dst = 3'd0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] data,
                      input logic [3:0] mask, input logic scalar);
        wr_en     = 1'b1;
        wr_sel    = sel;
        wr_data   = data;
        wr_mask   = mask;
        wr_scalar = scalar;
    endtask

    task automatic iss(input logic [2:0] dst);
        issue_en  = 1'b1;
        issue_dst = dst;
    endtask

    task automatic rd(input logic [2:0] s1, input logic [2:0] s2);
        rd_sel1 = s1;
        rd_sel2 = s2;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [7:0] bz, input logic hz, input logic [W-1:0] mask);
        exp_q.push_back({d1, d2, bz, hz});
        msk_q.push_back(mask);
        name_q.push_back(name);
        chk_valid = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (chk_valid && exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] m;
            logic [W-1:0] a;
            string        n;
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            n = name_q.pop_front();
            a = {32'(rd_data1), 32'(rd_data2), busy, hazard};
            if (m[72:41] != 0) begin
                total++;
                if (a[72:41] != e[72:41]) begin
                    bad++;
                    $display("FAIL %s rd_data1 got=%h want=%h", n, a[72:41], e[72:41]);
                end
            end
            if (m[40:9] != 0) begin
                total++;
                if (a[40:9] != e[40:9]) begin
                    bad++;
                    $display("FAIL %s rd_data2 got=%h want=%h", n, a[40:9], e[40:9]);
                end
            end
            if (m[8:1] != 0) begin
                total++;
                if (a[8:1] != e[8:1]) begin
                    bad++;
                    $display("FAIL %s busy got=%h want=%h", n, a[8:1], e[8:1]);
                end
            end
            if (m[0]) begin
                total++;
                if (a[0] != e[0]) begin
                    bad++;
                    $display("FAIL %s hazard got=%0b want=%0b", n, a[0], e[0]);
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; chk_valid = 1'b0;
        reset = 1'b1; rd_sel1 = 3'd0; rd_sel2 = 3'd0;
        wr_en = 1'b0; wr_sel = 3'd0; wr_scalar = 1'b0; wr_mask = 4'h0; wr_data = '0;
        issue_en = 1'b0; issue_dst = 3'd0;
        repeat (2) @(posedge clk);

        cyc(); rd(3, 3);
        expect_out("reset", 32'h0, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); wr(2, 32'h44332211, 4'b0101, 1'b0); rd(2, 3);
        expect_out("mask_bypass", 32'h00330011, 32'h0, 8'h00, 1'b0, M_D1 | M_D2);

        cyc(); rd(2, 2);
        expect_out("mask_stored", 32'h00330011, 32'h00330011, 8'h00, 1'b0, M_D1 | M_D2);

        cyc(); wr(5, 32'hAABBCCDD, 4'b1111, 1'b1); rd(5, 2);
        expect_out("scalar_bypass", 32'h000000DD, 32'h00330011, 8'h00, 1'b0, M_D1 | M_D2);

        cyc(); wr(0, 32'hFFFFFFFF, 4'b1111, 1'b0); rd(0, 5);
        expect_out("zero_bypass", 32'h0, 32'h000000DD, 8'h00, 1'b0, M_D1 | M_D2);

        cyc(); iss(4); rd(0, 4);
        expect_out("zero_hold_issue", 32'h0, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); rd(4, 0);
        expect_out("busy4", 32'h0, 32'h0, 8'h10, 1'b1, M_BZ | M_HZ);

        cyc(); wr(4, 32'h07070707, 4'b1111, 1'b0); rd(4, 0);
        expect_out("wb4_bypass", 32'h07070707, 32'h0, 8'h10, 1'b0, M_D1 | M_BZ | M_HZ);

        cyc(); rd(4, 0);
        expect_out("wb4_done", 32'h07070707, 32'h0, 8'h00, 1'b0, M_D1 | M_BZ | M_HZ);

        cyc(); iss(7); rd(1, 1);
        cyc(); wr(7, 32'h09090909, 4'b0001, 1'b0); rd(7, 7);
        expect_out("partial_clears_hz", 32'h00000009, 32'h00000009, 8'h80, 1'b0,
                   M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); rd(7, 3);
        expect_out("partial_done", 32'h00000009, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); iss(6); rd(1, 1);
        cyc(); iss(6); wr(6, 32'h55555555, 4'b1111, 1'b0); rd(6, 1);
        expect_out("issue_wb_same", 32'h55555555, 32'h0, 8'h40, 1'b0, M_D1 | M_BZ | M_HZ);

        cyc(); rd(6, 6);
        expect_out("issue_wins", 32'h55555555, 32'h55555555, 8'h40, 1'b1,
                   M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); iss(0); rd(0, 3);
        expect_out("issue0_pre", 32'h0, 32'h0, 8'h40, 1'b0, M_D1 | M_BZ | M_HZ);

        cyc(); rd(0, 3);
        expect_out("issue0_ignored", 32'h0, 32'h0, 8'h40, 1'b0, M_D1 | M_BZ | M_HZ);

        cyc(); iss(1); rd(3, 3);
        cyc(); iss(3); rd(3, 1);
        expect_out("busy_1_6", 32'h0, 32'h0, 8'h42, 1'b1, M_BZ | M_HZ);

        cyc(); reset = 1'b1; iss(5); wr(1, 32'hEEEEEEEE, 4'b1111, 1'b0); rd(3, 3);
        expect_out("pre_reset", 32'h0, 32'h0, 8'h4A, 1'b0, M_BZ);

        cyc(); rd(1, 5);
        expect_out("post_reset_a", 32'h0, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); rd(2, 6);
        expect_out("post_reset_b", 32'h0, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_BZ | M_HZ);

        cyc(); rd(4, 7);
        expect_out("post_reset_c", 32'h0, 32'h0, 8'h00, 1'b0, M_D1 | M_D2 | M_HZ);

        // bounded drain of the expected queue
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
        end
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
